tms_rom_loader: RTL
===================

// Module: tms_rom_loader
// PURPOSE
//  Boot-time program loader feeding the TMS1x00 core's OpenRAM program store.
//  After reset it streams WORDS 32-bit words from external SPI flash (READ 0x03)
//  and writes them into OpenRAM through its write port.
//  It holds the CPU in reset until the image is complete; the core then fetches
//  bytes through the RAM read port.
// PARAMETERS
//  FLASH_BASE  24'h000000  flash byte address of program image byte 0
//  WORDS       512         32-bit words to load (2048 bytes, RAM addr 0..WORDS-1)
//  CLK_DIV     2           wb_clk_i cycles per SCK half-period (>=1)
// PORTS
//  wb_clk_i     in   1   system clock
//  wb_rst_n     in   1   asynchronous reset, active low
//  reload       in   1   1-cycle pulse: restart a full load (ignored while busy)
//  spi_sck      out  1   flash clock, SPI mode 0
//  spi_cs_n     out  1   flash chip select, active low
//  spi_mosi     out  1   flash data in, MSB first
//  spi_miso     in   1   flash data out
//  ram_csb      out  1   OpenRAM write-port select, active low
//  ram_web      out  1   OpenRAM write enable, active low
//  ram_wmask    out  4   byte write mask
//  ram_addr     out  9   word address
//  ram_din      out  32  write data
//  busy         out  1   load in progress
//  cpu_reset    out  1   reset to tms1x00; high until first load completes
// BEHAVIOUR
//  Reset values: spi_sck=0, spi_cs_n=1, spi_mosi=0, ram_csb=1, ram_web=1,
//    ram_wmask=0, ram_addr=0, ram_din=0, busy=0, cpu_reset=1.
//  FSM: IDLE -> CMD -> ADDR -> DATA <-> WRITE -> FINISH -> IDLE.
//  IDLE: entered from reset; moves to CMD on the first clock after wb_rst_n
//    deasserts, and on reload=1. Transition asserts busy=1, cpu_reset=1,
//    spi_cs_n=0, and zeroes the word and bit counters.
//  CMD: shift 8'h03. ADDR: shift FLASH_BASE[23:0]. Both are MSB first.
//  SCK timing: toggles every CLK_DIV clocks. mosi changes on the falling edge
//    (or at CS assert for bit 0). miso is sampled on the rising edge.
//  DATA: shift in 32 bits as 4 bytes. Flash byte n goes to ram_din[8*n+7:8*n],
//    so byte 0 is the LSB (matches the core's byte select on ram_addr[1:0]).
//  WRITE: starts the clock after the 32nd rising-edge sample, with SCK held low.
//    It drives ram_csb=0, ram_web=0, ram_wmask=4'hF for exactly 1 cycle, with
//    ram_addr=word index and ram_din=assembled word. Then ram_csb/ram_web
//    return to 1 and wmask to 0.
//  After WRITE the word index increments. If index==WORDS, go to FINISH;
//    else return to DATA. CS stays low (continuous read, no re-command).
//  FINISH: spi_cs_n=1 and SCK=0 for one cycle, then busy=0 and cpu_reset=0.
//    Return to IDLE.
//  Word counter is 10 bits. ram_addr = counter[8:0]. No wrap past WORDS-1.
//  reload while busy: ignored. reload while IDLE: cpu_reset=1 again for the
//    whole reload.
//  wb_rst_n low mid-load: all outputs go to reset values immediately.
//    Partial RAM contents are left as-is. A full reload starts after release.
//  Throughput: 64*CLK_DIV clocks per word, plus 1 write clock.
//    Header is 64*CLK_DIV clocks.
// TESTING
//  Reset release, flash model holds 0x00..0xFF pattern at FLASH_BASE
//    -> MOSI shows 0x03 then 0x000000; RAM word 0 = 32'h03020100,
//    word 511 = 32'hFFFEFDFC.
//  Count writes during the load -> exactly 512 write strobes, each 1 cycle
//    with wmask=F, addresses 0..511 in order.
//  cpu_reset check -> stays 1 until FINISH; falls the cycle after spi_cs_n
//    rises; busy falls on the same cycle.
//  Assert wb_rst_n low at word 100 -> outputs take reset values
//    asynchronously; after release the load restarts at word 0 with a new
//    0x03 command.
//  reload pulse at word 50 -> ignored (512 writes total). reload pulse in
//    IDLE -> cpu_reset=1, second full 512-word load.
//  CLK_DIV=1 and CLK_DIV=4 -> SCK period is 2 and 8 clocks; data identical.

Source files
------------

// File: rtl/tms_rom_loader.sv
// ---------------------------------------------------------------------------
// tms_rom_loader
//
// Boot-time program loader for the TMS1x00 core. After reset (or a reload
// pulse while idle) it issues a SPI READ (0x03) to external flash at
// FLASH_BASE and streams WORDS 32-bit words into the OpenRAM program store
// through its write port. The CPU is held in reset until the image is loaded.
//
// Ports
//   wb_clk_i   in   system clock
//   wb_rst_n   in   asynchronous reset, active low
//   reload     in   1-cycle pulse, restarts a full load (ignored while busy)
//   spi_sck    out  flash clock, SPI mode 0
//   spi_cs_n   out  flash chip select, active low
//   spi_mosi   out  flash data in, MSB first
//   spi_miso   in   flash data out
//   ram_csb    out  OpenRAM write-port select, active low
//   ram_web    out  OpenRAM write enable, active low
//   ram_wmask  out  byte write mask
//   ram_addr   out  word address
//   ram_din    out  write data (flash byte n lands in bits [8n+7:8n])
//   busy       out  load in progress
//   cpu_reset  out  reset to the core, high until a load completes
//   dbg_state  out  current FSM state encoding (state_t)
//
// RAM write protocol: the write port has no back-pressure. A write is a
// single-cycle strobe: ram_csb=0, ram_web=0, ram_wmask=4'hF with ram_addr and
// ram_din valid in that same cycle; the RAM must accept it unconditionally.
// ---------------------------------------------------------------------------
module tms_rom_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          WORDS      = 512,
  parameter int          CLK_DIV    = 2      // clocks per SCK half-period, 1..256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        reload,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        ram_csb,
  output logic        ram_web,
  output logic [3:0]  ram_wmask,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic        busy,
  output logic        cpu_reset,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [9:0]  LAST_WORD = 10'(WORDS - 1);
  // Command byte followed by the 24-bit address, shifted out as one word.
  localparam logic [31:0] HDR       = {8'h03, FLASH_BASE};

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_div;
  logic        r_sck;
  logic        r_cs_n;
  logic        r_mosi;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic [4:0]  r_bit;
  logic [9:0]  r_word;
  logic        r_boot;
  logic        r_ram_csb;
  logic        r_ram_web;
  logic [3:0]  r_ram_wmask;
  logic [8:0]  r_ram_addr;
  logic [31:0] r_ram_din;
  logic        r_busy;
  logic        r_cpu_reset;

  logic        w_shifting;
  logic        w_tick;
  logic        w_rise;
  logic        w_fall;
  logic        w_last_bit;
  logic [31:0] w_word;

  assign w_shifting = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_tick     = w_shifting && (r_div == DIV_LAST);
  assign w_rise     = w_tick && !r_sck;
  assign w_fall     = w_tick && r_sck;
  assign w_last_bit = (r_bit == 5'd31);
  // The first byte received sits in r_rx[31:24]; it must become the LSB.
  assign w_word     = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. Bit boundaries are the SCK falling edges: the bit
  // counter advances there, so a byte/word is complete on the fall that
  // follows its last rising-edge sample.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (r_boot || reload)        w_state_next = S_CMD;
      S_CMD:    if (w_fall && r_bit == 5'd7) w_state_next = S_ADDR;
      S_ADDR:   if (w_fall && w_last_bit)    w_state_next = S_DATA;
      S_DATA:   if (w_fall && w_last_bit)    w_state_next = S_WRITE;
      S_WRITE:  w_state_next = (r_word == LAST_WORD) ? S_FINISH : S_DATA;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_div       <= 8'd0;
      r_sck       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_tx        <= 32'd0;
      r_rx        <= 32'd0;
      r_bit       <= 5'd0;
      r_word      <= 10'd0;
      r_boot      <= 1'b1;
      r_ram_csb   <= 1'b1;
      r_ram_web   <= 1'b1;
      r_ram_wmask <= 4'h0;
      r_ram_addr  <= 9'd0;
      r_ram_din   <= 32'd0;
      r_busy      <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          // r_boot makes the first clock after reset release start a load.
          if (r_boot || reload) begin
            r_boot      <= 1'b0;
            r_busy      <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_cs_n      <= 1'b0;
            r_sck       <= 1'b0;
            r_div       <= 8'd0;
            r_bit       <= 5'd0;
            r_word      <= 10'd0;
            r_tx        <= HDR;
            r_mosi      <= HDR[31];   // bit 0 is presented at CS assert
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (w_tick) begin
            r_div <= 8'd0;
            r_sck <= ~r_sck;
          end else begin
            r_div <= r_div + 8'd1;
          end

          if (w_rise && r_state == S_DATA) begin
            r_rx <= {r_rx[30:0], spi_miso};
          end

          if (w_fall) begin
            r_bit <= r_bit + 5'd1;
            if (r_state != S_DATA) begin
              r_tx   <= {r_tx[30:0], 1'b0};
              r_mosi <= r_tx[30];
            end
            if (r_state == S_DATA && w_last_bit) begin
              r_ram_csb   <= 1'b0;
              r_ram_web   <= 1'b0;
              r_ram_wmask <= 4'hF;
              r_ram_addr  <= r_word[8:0];
              r_ram_din   <= w_word;
            end
          end
        end

        S_WRITE: begin
          r_ram_csb   <= 1'b1;
          r_ram_web   <= 1'b1;
          r_ram_wmask <= 4'h0;
          r_word      <= r_word + 10'd1;
          r_div       <= 8'd0;
          // Flash stays selected between words (continuous read).
          if (r_word == LAST_WORD) begin
            r_cs_n <= 1'b1;
          end
        end

        S_FINISH: begin
          r_busy      <= 1'b0;
          r_cpu_reset <= 1'b0;
        end

        default: begin
          r_cs_n <= 1'b1;
        end
      endcase
    end
  end

  assign spi_sck   = r_sck;
  assign spi_cs_n  = r_cs_n;
  assign spi_mosi  = r_mosi;
  assign ram_csb   = r_ram_csb;
  assign ram_web   = r_ram_web;
  assign ram_wmask = r_ram_wmask;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign busy      = r_busy;
  assign cpu_reset = r_cpu_reset;
  assign dbg_state = r_state;

endmodule
